// File: rtl/lgn_mnist_pkg.sv
// Shared constants and helpers for the LGN MNIST image path (receiver and classifier).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lgn_mnist_pkg;

    // Default image geometry: 16x16 binary pixels, 8 pixels per transferred byte.
    localparam int DEF_ROWS = 16;
    localparam int DEF_COLS = 16;
    localparam int DEF_BPF  = DEF_ROWS * DEF_COLS / 8;

    // Width of the byte index counter for the default geometry.
    localparam int CNT_W = $clog2(DEF_BPF);

    // Receiver FSM encoding, kept as plain constants so older tools can consume it.
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] LOAD = 1'b1;

    // Flat frame bit holding pixel (row, col). Pixel (0,0) is the MSB of the frame
    // vector, and pixels run left to right, top to bottom towards the LSB.
    function automatic int unsigned pixel_index(
        input int unsigned row,
        input int unsigned col,
        input int unsigned rows,
        input int unsigned cols
    );
        return rows * cols - 1 - (row * cols + col);
    endfunction

endpackage

// File: rtl/lgn_frame_shadow.sv
// Frame assembly buffer plus the published shadow copy seen by the classifier.
// Latency: a byte written with commit is visible in frame_out after the same edge.
// Backpressure: none; every write is accepted, clear has priority over everything.
module lgn_frame_shadow
    import lgn_mnist_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int COLS  = DEF_COLS,
    parameter int IDX_W = CNT_W
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [7:0]             wr_byte,
    input  logic                   commit,
    output logic [ROWS*COLS-1:0]   frame_out
);

    localparam int NBITS = ROWS * COLS;
    localparam int BIT_W = $clog2(NBITS);

    logic [NBITS-1:0] asm_q;
    logic [NBITS-1:0] asm_d;
    int unsigned      pix;
    int unsigned      msb;
    logic [BIT_W-1:0] msb_idx;

    // Merge the incoming byte into the buffer image; byte k's first pixel is pixel 8k.
    always_comb begin
        asm_d   = asm_q;
        pix     = 8 * int'(wr_idx);
        msb     = pixel_index(pix / COLS, pix % COLS, ROWS, COLS);
        msb_idx = BIT_W'(msb);
        if (wr_en) begin
            asm_d[msb_idx -: 8] = wr_byte;
        end
    end

    // Buffer update and shadow publish. Commit uses the merged image so the last
    // byte of a frame lands in frame_out on the same edge it is written.
    always_ff @(posedge clk) begin
        if (clear) begin
            asm_q     <= '0;
            frame_out <= '0;
        end else begin
            if (wr_en) begin
                asm_q <= asm_d;
            end
            if (commit) begin
                frame_out <= asm_d;
            end
        end
    end

endmodule

// File: rtl/lgn_frame_receiver.sv
// Byte-serial frame receiver: assembles ROWSxCOLS binary frames for the LGN classifier.
// Latency: frame_valid/frame_out one cycle after the last byte's valid cycle.
// Backpressure: none; byte_valid is never stalled, idle cycles simply hold the FSM.
// Build option: LGN_RX_FREE_RUN_EN selects unsynchronised free-running byte indexing.
module lgn_frame_receiver
    import lgn_mnist_pkg::*;
#(
    parameter  int ROWS = DEF_ROWS,
    parameter  int COLS = DEF_COLS,
    localparam int BPF  = ROWS * COLS / 8,
    localparam int CW   = (BPF > 1) ? $clog2(BPF) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    input  logic                  frame_start,
    output logic [ROWS*COLS-1:0]  frame_out,
    output logic                  frame_valid,
    output logic                  frame_abort,
    output logic                  busy,
    output logic [CW-1:0]         byte_count
);

    localparam logic [CW-1:0] LAST_IDX = CW'(BPF - 1);
    localparam logic [CW-1:0] ONE_IDX  = CW'(1);

`ifdef LGN_RX_FREE_RUN_EN
    localparam logic [0:0] RST_STATE = LOAD;
`else
    localparam logic [0:0] RST_STATE = IDLE;
`endif

    logic [0:0]    state_q;
    logic [0:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          valid_q;
    logic          valid_d;
    logic          abort_q;
    logic          abort_d;
    logic          wr_en;
    logic [CW-1:0] wr_idx;
    logic          commit;

`ifdef LGN_RX_FREE_RUN_EN
    // The sender carries no sync marker in this mode.
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
`endif

    // Next-state, byte placement and pulse generation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = cnt_q;
        commit  = 1'b0;
        valid_d = 1'b0;
        abort_d = 1'b0;
`ifdef LGN_RX_FREE_RUN_EN
        state_d = LOAD;
        if (byte_valid) begin
            wr_en = 1'b1;
            if (cnt_q == LAST_IDX) begin
                commit  = 1'b1;
                valid_d = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + ONE_IDX;
            end
        end
`else
        if (frame_start) begin
            // A start always restarts assembly; it only counts as an abort when a
            // partial frame is actually being thrown away, and it wins over a
            // simultaneous last byte.
            state_d = LOAD;
            abort_d = (state_q == LOAD) && (cnt_q != '0);
            wr_idx  = '0;
            if (byte_valid) begin
                wr_en = 1'b1;
                cnt_d = ONE_IDX;
            end else begin
                cnt_d = '0;
            end
        end else if ((state_q == LOAD) && byte_valid) begin
            wr_en = 1'b1;
            if (cnt_q == LAST_IDX) begin
                commit  = 1'b1;
                valid_d = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + ONE_IDX;
            end
        end
`endif
    end

    // FSM, byte counter and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            abort_q <= abort_d;
        end
    end

    lgn_frame_shadow #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .IDX_W (CW)
    ) u_shadow (
        .clk       (clk),
        .clear     (rst),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_byte   (byte_in),
        .commit    (commit),
        .frame_out (frame_out)
    );

    assign frame_valid = valid_q;
    assign frame_abort = abort_q;
    assign busy        = (state_q == LOAD);
    assign byte_count  = cnt_q;

endmodule
